nmi_rr_arbiter: RTL and testbench
=================================

// Module: nmi_rr_arbiter
// PURPOSE
//  N-master to 1-slave arbiter for the native memory interface (valid/addr/wdata/wstrb/rdata/ready).
//  Parametrised in master count, address width and data width; round-robin fair.
//  Sits between CPU/DMA/debug masters and a shared NMI slave (SRAM, peripheral crossbar).
//  Holds the grant until the slave completes the transfer. No interleaving.
// PARAMETERS
//  NUM_MST     2             number of masters, 2..8
//  ADDR_WIDTH  32            address width
//  DATA_WIDTH  32            data width, multiple of 8; strobe width is DATA_WIDTH/8
//  TIMEOUT_CYC 1024          slave-response timeout in cycles (only used with NMI_ARB_TIMEOUT_EN)
//  ERR_DATA    32'hDEAD_BEEF rdata returned on timeout, zero-extended or truncated to DATA_WIDTH
// PORTS
//  clk_i        in   1                       clock
//  rst_i        in   1                       synchronous, active-high reset
//  m_valid_i    in   NUM_MST                 per-master request
//  m_addr_i     in   NUM_MST*ADDR_WIDTH      packed; master k occupies slice k
//  m_wdata_i    in   NUM_MST*DATA_WIDTH      packed write data
//  m_wstrb_i    in   NUM_MST*DATA_WIDTH/8    packed byte strobes; all-zero means read
//  m_rdata_o    out  DATA_WIDTH              read data, broadcast to all masters
//  m_ready_o    out  NUM_MST                 per-master completion pulse
//  s_valid_o    out  1                       slave request
//  s_addr_o     out  ADDR_WIDTH              slave address
//  s_wdata_o    out  DATA_WIDTH              slave write data
//  s_wstrb_o    out  DATA_WIDTH/8            slave byte strobes
//  s_rdata_i    in   DATA_WIDTH              slave read data
//  s_ready_i    in   1                       slave completion
//  grant_o      out  $clog2(NUM_MST)         index of the current/last granted master
//  timeout_o    out  1                       1-cycle pulse when a transfer is aborted on timeout
// BEHAVIOUR
//  - Reset values: s_valid_o=0, m_ready_o=0, grant_o=0, timeout_o=0, FSM=IDLE, rr pointer last=NUM_MST-1.
//  - FSM IDLE:
//    - If any m_valid_i is high, register winner = first requester searching last+1, last+2, ... (mod NUM_MST).
//    - grant_o <= winner; next state BUSY.
//    - No request: stay in IDLE.
//  - FSM BUSY:
//    - s_valid_o = m_valid_i[grant]; s_addr/wdata/wstrb are combinational from slice grant.
//    - m_ready_o[grant] = s_ready_i; m_rdata_o = s_rdata_i. Zero added latency on the response path.
//    - On s_valid_o & s_ready_i: last <= grant; next state IDLE.
//  - Latency: request seen in cycle 0 -> s_valid_o in cycle 1. Best-case single-transfer turnaround is 2 cycles.
//  - Back-to-back: after completion, one IDLE cycle precedes the next grant.
//    The same master is re-granted only if no other master requests.
//  - In IDLE, s_valid_o=0 and s_* outputs are don't-care.
//  - m_ready_o bits other than grant are always 0.
//  - NMI rule: a master holds valid/addr/wdata/wstrb stable until its ready.
//    If the granted master drops valid in BUSY (protocol violation): FSM returns to IDLE and last is unchanged.
//  - s_ready_i while s_valid_o=0 is ignored.
//  - Simultaneous requests from all masters: strict rotation. Worst-case wait is NUM_MST-1 transfers.
//  - Reset mid-transfer: FSM -> IDLE immediately. No m_ready_o is issued for the aborted transfer.
// CONFIGURATION
//  NMI_ARB_TIMEOUT_EN defined:
//    - Counter clears on entry to BUSY and increments each BUSY cycle without s_ready_i.
//    - When the count reaches TIMEOUT_CYC-1 without s_ready_i, that cycle:
//      s_valid_o forced 0, m_ready_o[grant]=1, m_rdata_o=ERR_DATA, timeout_o=1; last <= grant; FSM -> IDLE.
//    - If s_ready_i coincides with the timeout cycle, the normal completion wins and timeout_o stays 0.
//  NMI_ARB_TIMEOUT_EN undefined:
//    - No counter; timeout_o tied 0; a hung slave stalls the arbiter indefinitely.
// TESTING
//  1. Reset with m_valid_i=all-ones -> s_valid_o=0, m_ready_o=0 during reset; first grant after release is master 0.
//  2. NUM_MST=4, all request continuously, slave ready 1 cycle after valid -> grant_o sequence 0,1,2,3,0.
//  3. Master 2 reads addr 0x1000, slave returns 0xCAFE_F00D after 3 wait cycles
//     -> m_ready_o=4'b0100 for exactly 1 cycle with m_rdata_o=0xCAFE_F00D.
//  4. Master 1 writes wstrb=4'b0011, wdata=0x1234_5678 while master 0 requests
//     -> slave sees master 1 slice unchanged; master 0 is granted afterwards.
//  5. With NMI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, slave never ready
//     -> at BUSY cycle 16: m_ready_o pulse, m_rdata_o=0xDEAD_BEEF, timeout_o=1; next master served.
//  6. Assert rst_i during BUSY with s_ready_i arriving the same cycle
//     -> no m_ready_o pulse; FSM IDLE; grant_o=0 next cycle.

Source files
------------

// File: rtl/nmi_rr_arbiter.sv
// Round-robin N-master to 1-slave arbiter for the native memory interface.
// Optional slave-response timeout is enabled by defining NMI_ARB_TIMEOUT_EN.
module nmi_rr_arbiter #(
  parameter int          NUM_MST     = 2,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_MST-1:0]               m_valid_i,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]    m_addr_i,
  input  logic [NUM_MST*DATA_WIDTH-1:0]    m_wdata_i,
  input  logic [NUM_MST*DATA_WIDTH/8-1:0]  m_wstrb_i,
  output logic [DATA_WIDTH-1:0]            m_rdata_o,
  output logic [NUM_MST-1:0]               m_ready_o,
  output logic                             s_valid_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          s_wstrb_o,
  input  logic [DATA_WIDTH-1:0]            s_rdata_i,
  input  logic                             s_ready_i,
  output logic [$clog2(NUM_MST)-1:0]       grant_o,
  output logic                             timeout_o
);

  localparam int GW = $clog2(NUM_MST);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_q, last_d;
  logic [GW-1:0]           winner_s;
  logic                    sel_valid_s;
  logic                    tmo_s;
  logic                    s_valid_s;
  logic                    timeout_s;
  logic [NUM_MST-1:0]      m_ready_s;
  logic [DATA_WIDTH-1:0]   err_data_s;

  assign err_data_s  = DATA_WIDTH'(ERR_DATA);
  assign sel_valid_s = m_valid_i[grant_q];

  // Scan from the master after the last served one; lowest offset wins.
  always_comb begin
    winner_s = last_q;
    for (int i = NUM_MST; i >= 1; i--) begin
      if (m_valid_i[(int'(last_q) + i) % NUM_MST]) begin
        winner_s = GW'((int'(last_q) + i) % NUM_MST);
      end else begin
        winner_s = winner_s;
      end
    end
  end

`ifdef NMI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!s_ready_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign tmo_s = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^32'(TIMEOUT_CYC);
  assign tmo_s        = 1'b0;
`endif

  // Next-state and response logic; a ready always beats a coincident timeout.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    s_valid_s = 1'b0;
    m_ready_s = '0;
    m_rdata_o = s_rdata_i;
    timeout_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (|m_valid_i) begin
          grant_d = winner_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!sel_valid_s) begin
          state_d = IDLE;
        end else if (s_ready_i) begin
          s_valid_s          = 1'b1;
          m_ready_s[grant_q] = 1'b1;
          last_d             = grant_q;
          state_d            = IDLE;
        end else if (tmo_s) begin
          m_ready_s[grant_q] = 1'b1;
          m_rdata_o          = err_data_s;
          timeout_s          = 1'b1;
          last_d             = grant_q;
          state_d            = IDLE;
        end else begin
          s_valid_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset suppresses any handshake in flight in the same cycle.
  assign s_valid_o = s_valid_s & ~rst_i;
  assign m_ready_o = m_ready_s & {NUM_MST{~rst_i}};
  assign timeout_o = timeout_s & ~rst_i;
  assign grant_o   = grant_q;

  assign s_addr_o  = m_addr_i[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_wdata_o = m_wdata_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign s_wstrb_o = m_wstrb_i[grant_q*SW +: SW];

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_MST - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// Directed self-checking bench for nmi_rr_arbiter with four masters.
// The timeout scenario runs only when NMI_ARB_TIMEOUT_EN is defined.
module tb_nmi_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NM-1:0]     m_valid_i;
  logic [NM*AW-1:0]  m_addr_i;
  logic [NM*DW-1:0]  m_wdata_i;
  logic [NM*4-1:0]   m_wstrb_i;
  logic [DW-1:0]     m_rdata_o;
  logic [NM-1:0]     m_ready_o;
  logic              s_valid_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_wdata_o;
  logic [3:0]        s_wstrb_o;
  logic [DW-1:0]     s_rdata_i;
  logic              s_ready_i;
  logic [1:0]        grant_o;
  logic              timeout_o;

  int checks_q   = 0;
  int failures_q = 0;

  nmi_rr_arbiter #(
    .NUM_MST(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYC(16), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_valid_i(m_valid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_wstrb_i(m_wstrb_i), .m_rdata_o(m_rdata_o), .m_ready_o(m_ready_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_q++;
    if (obs !== exp) begin
      failures_q++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i     = 1'b1;
    m_valid_i = 4'b1111;
    s_ready_i = 1'b0;
    s_rdata_i = 32'h0000_0000;
    m_wdata_i = '0;
    m_wstrb_i = '0;
    for (int k = 0; k < NM; k++) m_addr_i[k*AW +: AW] = 32'h1000_0000 + 32'(k * 16);

    // Reset with every master requesting.
    tick();
    s_ready_i = 1'b1;
    #1;
    check_val("rst_svalid", 64'(s_valid_o), 64'd0);
    check_val("rst_mready", 64'(m_ready_o), 64'd0);
    check_val("rst_grant", 64'(grant_o), 64'd0);
    check_val("rst_tmo", 64'(timeout_o), 64'd0);
    rst_i     = 1'b0;
    s_ready_i = 1'b0;
    #1;
    check_val("idle_svalid", 64'(s_valid_o), 64'd0);
    tick();

    // Strict rotation under continuous requests, ready one cycle after valid.
    for (int i = 0; i < 5; i++) begin
      check_val("rot_grant", 64'(grant_o), 64'(i % 4));
      check_val("rot_svalid", 64'(s_valid_o), 64'd1);
      check_val("rot_addr", 64'(s_addr_o), 64'(32'h1000_0000 + 32'((i % 4) * 16)));
      check_val("rot_wait", 64'(m_ready_o), 64'd0);
      tick();
      s_ready_i = 1'b1;
      #1;
      check_val("rot_ready", 64'(m_ready_o), 64'(4'b0001 << (i % 4)));
      tick();
      s_ready_i = 1'b0;
      if (i == 4) m_valid_i = 4'b0000;
      #1;
      check_val("rot_gap", 64'(s_valid_o), 64'd0);
      tick();
    end

    // Master 1 write while master 0 waits; last pointer is 0 here.
    m_addr_i[1*AW +: AW]  = 32'h0000_2000;
    m_wdata_i[1*DW +: DW] = 32'h1234_5678;
    m_wstrb_i[1*4 +: 4]   = 4'b0011;
    m_addr_i[0*AW +: AW]  = 32'h0000_3000;
    m_wdata_i[0*DW +: DW] = 32'hAAAA_5555;
    m_valid_i             = 4'b0011;
    tick();
    check_val("wr_grant", 64'(grant_o), 64'd1);
    check_val("wr_addr", 64'(s_addr_o), 64'h2000);
    check_val("wr_wdata", 64'(s_wdata_o), 64'h1234_5678);
    check_val("wr_wstrb", 64'(s_wstrb_o), 64'b0011);
    s_ready_i = 1'b1;
    #1;
    check_val("wr_ready", 64'(m_ready_o), 64'b0010);
    tick();
    s_ready_i = 1'b0;
    m_valid_i = 4'b0001;
    tick();
    check_val("m0_grant", 64'(grant_o), 64'd0);
    check_val("m0_addr", 64'(s_addr_o), 64'h3000);
    s_ready_i = 1'b1;
    #1;
    check_val("m0_ready", 64'(m_ready_o), 64'b0001);
    tick();
    m_valid_i = 4'b0000;
    #1;
    check_val("idle_ready_ign", 64'(m_ready_o), 64'd0);
    check_val("idle_svalid2", 64'(s_valid_o), 64'd0);
    s_ready_i = 1'b0;
    tick();

    // Master 2 read with three cycles of wait before the slave answers.
    m_addr_i[2*AW +: AW] = 32'h0000_1000;
    m_wstrb_i[2*4 +: 4]  = 4'b0000;
    m_valid_i            = 4'b0100;
    tick();
    check_val("rd_grant", 64'(grant_o), 64'd2);
    check_val("rd_addr", 64'(s_addr_o), 64'h1000);
    check_val("rd_wstrb", 64'(s_wstrb_o), 64'd0);
    for (int w = 0; w < 3; w++) begin
      check_val("rd_wait", 64'(m_ready_o), 64'd0);
      tick();
    end
    s_ready_i = 1'b1;
    s_rdata_i = 32'hCAFE_F00D;
    #1;
    check_val("rd_ready", 64'(m_ready_o), 64'b0100);
    check_val("rd_data", 64'(m_rdata_o), 64'hCAFE_F00D);
    tick();
    s_ready_i = 1'b0;
    m_valid_i = 4'b0000;
    #1;
    check_val("rd_pulse_end", 64'(m_ready_o), 64'd0);

    // Granted master drops valid: back to IDLE, pointer unchanged (still 2).
    m_valid_i = 4'b1000;
    tick();
    check_val("viol_grant", 64'(grant_o), 64'd3);
    m_valid_i = 4'b0000;
    #1;
    check_val("viol_svalid", 64'(s_valid_o), 64'd0);
    check_val("viol_mready", 64'(m_ready_o), 64'd0);
    tick();
    m_valid_i = 4'b1001;
    tick();
    check_val("viol_last", 64'(grant_o), 64'd3);

    // Reset during BUSY with a coincident slave ready.
    s_ready_i = 1'b1;
    rst_i     = 1'b1;
    #1;
    check_val("rstb_mready", 64'(m_ready_o), 64'd0);
    check_val("rstb_svalid", 64'(s_valid_o), 64'd0);
    tick();
    rst_i     = 1'b0;
    s_ready_i = 1'b0;
    #1;
    check_val("rstb_grant", 64'(grant_o), 64'd0);
    check_val("rstb_idle", 64'(s_valid_o), 64'd0);
    tick();
    check_val("rstb_regrant", 64'(grant_o), 64'd0);
    s_ready_i = 1'b1;
    #1;
    check_val("rstb_done", 64'(m_ready_o), 64'b0001);
    tick();
    s_ready_i = 1'b0;
    m_valid_i = 4'b0000;
    tick();

`ifdef NMI_ARB_TIMEOUT_EN
    // Hung slave: abort at the 16th BUSY cycle, then master 2 is served.
    s_rdata_i = 32'h1111_1111;
    m_valid_i = 4'b0110;
    tick();
    check_val("to_grant", 64'(grant_o), 64'd1);
    for (int c = 1; c < 16; c++) begin
      check_val("to_early", 64'({timeout_o, m_ready_o}), 64'd0);
      tick();
    end
    check_val("to_pulse", 64'(timeout_o), 64'd1);
    check_val("to_ready", 64'(m_ready_o), 64'b0010);
    check_val("to_rdata", 64'(m_rdata_o), 64'hDEAD_BEEF);
    check_val("to_svalid", 64'(s_valid_o), 64'd0);
    tick();
    m_valid_i = 4'b0100;
    #1;
    check_val("to_clear", 64'(timeout_o), 64'd0);
    tick();
    check_val("to_next", 64'(grant_o), 64'd2);
    s_ready_i = 1'b1;
    #1;
    check_val("to_next_rdy", 64'(m_ready_o), 64'b0100);
    check_val("to_next_tmo", 64'(timeout_o), 64'd0);
    tick();
    s_ready_i = 1'b0;
    m_valid_i = 4'b0000;
    tick();
`else
    // Without the timeout feature a stalled slave never raises timeout_o.
    m_valid_i = 4'b0010;
    for (int c = 0; c < 40; c++) tick();
    check_val("notmo_pulse", 64'(timeout_o), 64'd0);
    check_val("notmo_stall", 64'({s_valid_o, m_ready_o}), 64'h10);
    m_valid_i = 4'b0000;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
    $finish;
  end

endmodule
